// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  modport master (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           core_hold, busy, done, error, checksum
  );

  modport slave (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           core_hold, busy, done, error, checksum
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word_valid_o pulses the cycle after the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [1:0]  cnt_o,
  output logic [23:0] partial_o
);

  logic [1:0]  cnt_q;
  logic [23:0] asm_q;
  logic [31:0] word_q;
  logic        valid_q;
  logic        last;

  assign last = strobe_i && (cnt_q == 2'(WORD_BYTES - 1));

  // The 4th byte bypasses the assembly register straight into the completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= last;
      if (strobe_i) begin
        cnt_q <= cnt_q + 2'd1;
        case (cnt_q)
          2'd0:    asm_q[7:0]   <= byte_i;
          2'd1:    asm_q[15:8]  <= byte_i;
          2'd2:    asm_q[23:16] <= byte_i;
          default: word_q       <= {byte_i, asm_q};
        endcase
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign cnt_o        = cnt_q;
  assign partial_o    = asm_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a word-count header then streams words into instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  state_e            state_q, state_d;
  logic [31:0]       widx_q, widx_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       csum_q, csum_d;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] curAddr;

  logic        byteReady;
  logic        strobe;
  logic        startAcc;
  logic        hdrLast;
  logic        lastWrite;
  logic        wordValid;
  logic [31:0] word;
  logic [31:0] hdrWord;
  logic [1:0]  cnt;
  logic [23:0] partial;

  assign startAcc  = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign strobe    = bus.byte_valid && byteReady;
  assign hdrLast   = (state_q == ST_HDR) && strobe && (cnt == 2'(HDR_BYTES - 1));
  assign hdrWord   = {bus.byte_data, partial};
  assign lastWrite = wordValid && (widx_q == n_q - 32'd1);
  // Readiness drops during the final write so no stray byte follows the image.
  assign byteReady = (state_q == ST_HDR) || ((state_q == ST_LOAD) && !lastWrite);
  assign curAddr   = ADDR_W'({widx_q[29:0], 2'b00});

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe_i     (strobe),
    .byte_i       (bus.byte_data),
    .clear_i      (startAcc || hdrLast),
    .word_o       (word),
    .word_valid_o (wordValid),
    .cnt_o        (cnt),
    .partial_o    (partial)
  );

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    n_d     = n_q;
    csum_d  = csum_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_HDR;
          widx_d  = '0;
          n_d     = '0;
          csum_d  = '0;
        end
      end
      ST_HDR: begin
        if (hdrLast) begin
          n_d     = hdrWord;
          state_d = ((hdrWord == 32'd0) || (hdrWord > 32'(DEPTH))) ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wordValid) begin
          widx_d = widx_q + 32'd1;
          csum_d = csum_q ^ word;
          if (lastWrite) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
      n_q     <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      n_q     <= n_d;
      csum_q  <= csum_d;
      if (wordValid) begin
        addr_q  <= curAddr;
        wdata_q <= word;
      end
    end
  end

  assign bus.byte_ready = byteReady;
  assign bus.imem_we    = wordValid;
  assign bus.imem_addr  = wordValid ? curAddr : addr_q;
  assign bus.imem_wdata = wordValid ? word : wdata_q;
  assign bus.core_hold  = state_q inside {ST_HDR, ST_LOAD, ST_ERR};
  assign bus.busy       = state_q inside {ST_HDR, ST_LOAD};
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = (state_q == ST_ERR);
  assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic clk;
  logic rst_n;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  streamMem [0:15];
  logic [31:0] expData [0:2];
  logic [31:0] wrAddr [$];
  logic [31:0] wrData [$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wrAddr.push_back(bus.imem_addr);
      wrData.push_back(bus.imem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int first, input int count, input bit gapped);
    int budget;
    for (int i = first; i < first + count; i++) begin
      if (gapped) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = streamMem[i];
      budget = 0;
      while (!bus.byte_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.byte_ready) begin
        checkOutput("readyTimeout", 32'd0, 32'd1);
        bus.byte_valid = 1'b0;
        break;
      end
      @(posedge clk);
      #1 bus.byte_valid = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int budget = 0;
    while (!bus.done && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    checkOutput(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic setHeader(input logic [7:0] b0, b1, b2, b3);
    streamMem[0] = b0; streamMem[1] = b1; streamMem[2] = b2; streamMem[3] = b3;
  endtask

  task automatic loadNormalStream();
    setHeader(8'h03, 8'h00, 8'h00, 8'h00);
    streamMem[4]  = 8'h13; streamMem[5]  = 8'h00; streamMem[6]  = 8'h50; streamMem[7]  = 8'h00;
    streamMem[8]  = 8'h93; streamMem[9]  = 8'h00; streamMem[10] = 8'ha0; streamMem[11] = 8'h00;
    streamMem[12] = 8'h33; streamMem[13] = 8'h81; streamMem[14] = 8'h20; streamMem[15] = 8'h00;
  endtask

  function automatic logic [31:0] expChecksum();
    logic [31:0] acc = '0;
    for (int i = 0; i < 3; i++) acc ^= expData[i];
    return acc;
  endfunction

  task automatic checkNormalWrites(input string tag);
    checkOutput({tag, "_count"}, 32'(wrData.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wrData.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], 32'(i * 4));
        checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expData[i]);
      end
    end
    checkOutput({tag, "_csum"}, bus.checksum, expChecksum());
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "_hold"}, 32'(bus.core_hold), 32'd0);
  endtask

  initial begin
    expData[0] = 32'h00500013;
    expData[1] = 32'h00a00093;
    expData[2] = 32'h00208133;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;

    #2;
    checkOutput("rst_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_addr", bus.imem_addr, 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_hold", 32'(bus.core_hold), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_error", 32'(bus.error), 32'd0);
    checkOutput("rst_csum", bus.checksum, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] normal 3-word load");
    loadNormalStream();
    pulseStart();
    @(negedge clk);
    checkOutput("start_ready", 32'(bus.byte_ready), 32'd1);
    checkOutput("start_busy", 32'(bus.busy), 32'd1);
    checkOutput("start_hold", 32'(bus.core_hold), 32'd1);
    applyStimulus(0, 16, 1'b0);
    @(negedge clk);
    checkOutput("last_we", 32'(bus.imem_we), 32'd1);
    checkOutput("last_addr", bus.imem_addr, 32'h8);
    checkOutput("last_wdata", bus.imem_wdata, expData[2]);
    checkOutput("last_csumPre", bus.checksum, expData[0] ^ expData[1]);
    checkOutput("last_notDone", 32'(bus.done), 32'd0);
    checkOutput("last_ready", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    checkOutput("after_we", 32'(bus.imem_we), 32'd0);
    checkOutput("after_addrHeld", bus.imem_addr, 32'h8);
    checkOutput("after_wdataHeld", bus.imem_wdata, expData[2]);
    checkOutput("after_busy", 32'(bus.busy), 32'd0);
    checkNormalWrites("normal");

    $display("[TB] zero header");
    wrAddr.delete(); wrData.delete();
    setHeader(8'h00, 8'h00, 8'h00, 8'h00);
    pulseStart();
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    checkOutput("zero_error", 32'(bus.error), 32'd1);
    checkOutput("zero_hold", 32'(bus.core_hold), 32'd1);
    checkOutput("zero_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("zero_done", 32'(bus.done), 32'd0);
    bus.byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.byte_valid = 1'b0;
    checkOutput("zero_noWrites", 32'(wrData.size()), 32'd0);

    $display("[TB] oversize headers");
    setHeader(8'h01, 8'h01, 8'h00, 8'h00);
    pulseStart();
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    checkOutput("over257_error", 32'(bus.error), 32'd1);
    setHeader(8'h01, 8'h00, 8'h00, 8'h80);
    pulseStart();
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    checkOutput("overTop_error", 32'(bus.error), 32'd1);
    setHeader(8'h00, 8'h01, 8'h00, 8'h00);
    pulseStart();
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    checkOutput("depth256_error", 32'(bus.error), 32'd0);
    checkOutput("depth256_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    $display("[TB] one-word load after error");
    setHeader(8'h01, 8'h01, 8'h00, 8'h00);
    pulseStart();
    applyStimulus(0, 4, 1'b0);
    @(negedge clk);
    checkOutput("preOne_error", 32'(bus.error), 32'd1);
    wrAddr.delete(); wrData.delete();
    setHeader(8'h01, 8'h00, 8'h00, 8'h00);
    streamMem[4] = 8'hef; streamMem[5] = 8'hbe; streamMem[6] = 8'had; streamMem[7] = 8'hde;
    pulseStart();
    @(negedge clk);
    checkOutput("one_errorCleared", 32'(bus.error), 32'd0);
    applyStimulus(0, 8, 1'b0);
    waitDone("one_done");
    checkOutput("one_count", 32'(wrData.size()), 32'd1);
    if (wrData.size() > 0) begin
      checkOutput("one_addr", wrAddr[0], 32'h0);
      checkOutput("one_data", wrData[0], 32'hdeadbeef);
    end
    checkOutput("one_csum", bus.checksum, 32'hdeadbeef);

    $display("[TB] gapped stream");
    wrAddr.delete(); wrData.delete();
    loadNormalStream();
    pulseStart();
    applyStimulus(0, 16, 1'b1);
    waitDone("gap_wait");
    @(negedge clk);
    checkNormalWrites("gap");

    $display("[TB] reset mid-load");
    wrAddr.delete(); wrData.delete();
    pulseStart();
    applyStimulus(0, 10, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRst_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("midRst_hold", 32'(bus.core_hold), 32'd0);
    checkOutput("midRst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midRst_csum", bus.checksum, 32'd0);
    checkOutput("midRst_wdata", bus.imem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wrAddr.delete(); wrData.delete();
    pulseStart();
    applyStimulus(0, 16, 1'b0);
    waitDone("postRst_wait");
    @(negedge clk);
    checkNormalWrites("postRst");

    $display("[TB] ignored start during load");
    wrAddr.delete(); wrData.delete();
    pulseStart();
    applyStimulus(0, 9, 1'b0);
    pulseStart();
    @(negedge clk);
    checkOutput("ign_busy", 32'(bus.busy), 32'd1);
    applyStimulus(9, 7, 1'b0);
    waitDone("ign_wait");
    @(negedge clk);
    checkNormalWrites("ign");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
